// File: rtl/pipe_stage_reg.sv
// Elastic register pipeline of STAGES valid/ready stages with synchronous flush.
// Define PIPE_STAGE_REG_STALL_CNT_EN to add the saturating stall_cnt output.
module pipe_stage_reg #(
    parameter int unsigned WIDTH  = 3,
    parameter int unsigned STAGES = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WIDTH-1:0]                 out_data,
    input  logic                             flush,
    output logic [$clog2(STAGES+1)-1:0]      occupancy
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
    ,
    output logic [15:0]                      stall_cnt
`endif
);

    localparam int unsigned OccW = $clog2(STAGES + 1);

    logic [STAGES-1:0]            valid_q, valid_d;
    logic [STAGES-1:0][WIDTH-1:0] data_q, data_d;
    logic [STAGES-1:0]            ready;
    logic [STAGES-1:0]            src_valid;
    logic [STAGES-1:0][WIDTH-1:0] src_data;
    logic [OccW-1:0]              occ_q, occ_d;
    logic                         ready_chain;

    // Ready ripples backwards from the output: a stage accepts if empty or draining.
    always_comb begin
        ready       = '0;
        ready_chain = out_ready;
        for (int i = int'(STAGES) - 1; i >= 0; i--) begin
            ready_chain = !valid_q[i] || ready_chain;
            ready[i]    = ready_chain;
        end
    end

    always_comb begin
        src_valid    = '0;
        src_data     = '0;
        src_valid[0] = in_valid;
        src_data[0]  = in_data;
        for (int i = 1; i < int'(STAGES); i++) begin
            src_valid[i] = valid_q[i-1];
            src_data[i]  = data_q[i-1];
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        for (int i = 0; i < int'(STAGES); i++) begin
            if (flush) begin
                valid_d[i] = 1'b0;
            end else if (ready[i]) begin
                valid_d[i] = src_valid[i];
                if (src_valid[i]) begin
                    data_d[i] = src_data[i];
                end
            end
        end
    end

    always_comb begin
        occ_d = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            occ_d = occ_d + OccW'(valid_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            occ_q   <= occ_d;
        end
    end

    assign in_ready  = ready[0] && !flush;
    assign out_valid = valid_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    assign occupancy = occ_q;

`ifdef PIPE_STAGE_REG_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (valid_q[STAGES-1] && !out_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (STAGES=1/3/2) checked against a
// queue-of-positions model every cycle, plus directed literal expectations.
module tb_pipe_stage_reg;

    logic       clk;
    logic       rst_n;
    logic       iv   [3];
    logic       ordy [3];
    logic       fl   [3];
    logic [7:0] idat [3];
    logic       ir   [3];
    logic       ov   [3];
    logic [2:0] od0;
    logic [7:0] od1, od2;
    logic [0:0] occ0;
    logic [1:0] occ1, occ2;
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
    logic [15:0] sc [3];
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Model: per instance, a list of held items (oldest first) and their stage index.
    int         mcnt   [3];
    int         mpos   [3][4];
    logic [7:0] mdat   [3][4];
    int         mstall [3];

    pipe_stage_reg #(.WIDTH(3), .STAGES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idat[0][2:0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od0), .flush(fl[0]), .occupancy(occ0)
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
        , .stall_cnt(sc[0])
`endif
    );

    pipe_stage_reg #(.WIDTH(8), .STAGES(3)) u_s3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idat[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od1), .flush(fl[1]), .occupancy(occ1)
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
        , .stall_cnt(sc[1])
`endif
    );

    pipe_stage_reg #(.WIDTH(8), .STAGES(2)) u_s2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(idat[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od2), .flush(fl[2]), .occupancy(occ2)
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
        , .stall_cnt(sc[2])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int stg(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 2);
    endfunction

    function automatic logic [7:0] mask(input int k);
        return (k == 0) ? 8'h07 : 8'hFF;
    endfunction

    function automatic logic [31:0] dut_od(input int k);
        return (k == 0) ? {29'd0, od0} : ((k == 1) ? {24'd0, od1} : {24'd0, od2});
    endfunction

    function automatic logic [31:0] dut_occ(input int k);
        return (k == 0) ? {31'd0, occ0} : ((k == 1) ? {30'd0, occ1} : {30'd0, occ2});
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Where each held item sits after one edge; the head leaves if it is at the end and popped.
    function automatic void step_pos(input int k, input logic pop_ok, output int npos[4],
                                     output int first);
        first = 0;
        for (int j = 0; j < 4; j++) npos[j] = (j < mcnt[k]) ? mpos[k][j] : 0;
        for (int j = 0; j < mcnt[k]; j++) begin
            if (j == 0) begin
                if (npos[0] == stg(k) - 1) begin
                    if (pop_ok) first = 1;
                end else begin
                    npos[0]++;
                end
            end else if ((j - 1 < first) || (npos[j-1] != npos[j] + 1)) begin
                npos[j]++;
            end
        end
    endfunction

    function automatic logic exp_ov(input int k);
        return (mcnt[k] > 0) && (mpos[k][0] == stg(k) - 1);
    endfunction

    function automatic logic exp_ir(input int k);
        int npos[4];
        int first;
        step_pos(k, ordy[k], npos, first);
        for (int j = first; j < mcnt[k]; j++) begin
            if (npos[j] == 0) return 1'b0;
        end
        return !fl[k];
    endfunction

    function automatic void model_commit(input int k);
        int   npos[4];
        int   first;
        int   nc;
        logic rdy;
        if (exp_ov(k) && !ordy[k] && mstall[k] < 65535) mstall[k]++;
        rdy = exp_ir(k);
        step_pos(k, ordy[k], npos, first);
        if (fl[k]) begin
            mcnt[k] = 0;
        end else begin
            nc = 0;
            for (int j = first; j < mcnt[k]; j++) begin
                mpos[k][nc] = npos[j];
                mdat[k][nc] = mdat[k][j];
                nc++;
            end
            if (iv[k] && rdy) begin
                mpos[k][nc] = 0;
                mdat[k][nc] = idat[k] & mask(k);
                nc++;
            end
            mcnt[k] = nc;
        end
    endfunction

    initial begin
        for (int k = 0; k < 3; k++) begin
            mcnt[k]   = 0;
            mstall[k] = 0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            for (int k = 0; k < 3; k++) begin
                if (!rst_n) begin
                    mcnt[k]   = 0;
                    mstall[k] = 0;
                end else begin
                    model_commit(k);
                end
            end
        end
    end

    // Compare every instance against the model mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                check($sformatf("out_valid[%0d]", k), {31'd0, ov[k]}, {31'd0, exp_ov(k)});
                if (exp_ov(k)) check($sformatf("out_data[%0d]", k), dut_od(k), {24'd0, mdat[k][0]});
                check($sformatf("occupancy[%0d]", k), dut_occ(k), mcnt[k]);
                check($sformatf("in_ready[%0d]", k), {31'd0, ir[k]}, {31'd0, exp_ir(k)});
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
                check($sformatf("stall_cnt[%0d]", k), {16'd0, sc[k]}, mstall[k]);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [23:0] iv_pat;
    logic [23:0] rd_pat;

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            iv[k]   = 1'b0;
            ordy[k] = 1'b1;
            fl[k]   = 1'b0;
            idat[k] = 8'h00;
        end
        tick();
        check("reset out_valid", {31'd0, ov[1]}, 32'd0);
        check("reset occupancy", dut_occ(1), 32'd0);
        check("reset in_ready", {31'd0, ir[1]}, 32'd1);
        tick();
        rst_n = 1'b1;

        // Single stage: 3'b101 in at cycle 0, out at cycle 1.
        iv[0]   = 1'b1;
        idat[0] = 8'h05;
        tick();
        iv[0] = 1'b0;
        check("s1 out_valid", {31'd0, ov[0]}, 32'd1);
        check("s1 out_data", dut_od(0), 32'h5);
        check("s1 occupancy", dut_occ(0), 32'd1);
        tick();

        // Three stages, back-to-back stream 1..4: outputs on cycles 3..6.
        for (int t = 0; t < 8; t++) begin
            iv[1]   = (t < 4);
            idat[1] = 8'(t + 1);
            #1;
            if (t < 4) check("s3 stream in_ready", {31'd0, ir[1]}, 32'd1);
            check("s3 stream out_valid", {31'd0, ov[1]}, {31'd0, (t >= 3 && t <= 6)});
            if (t >= 3 && t <= 6) check("s3 stream out_data", dut_od(1), t - 2);
            tick();
        end
        iv[1] = 1'b0;

        // Fill three stages under backpressure, stall five cycles, then pop+push together.
        ordy[1] = 1'b0;
        for (int t = 0; t < 3; t++) begin
            iv[1]   = 1'b1;
            idat[1] = 8'h10 + 8'(t);
            tick();
        end
        check("s3 full occupancy", dut_occ(1), 32'd3);
        idat[1] = 8'h20;
        for (int t = 0; t < 5; t++) begin
            check("s3 stall in_ready", {31'd0, ir[1]}, 32'd0);
            check("s3 stall out_data", dut_od(1), 32'h10);
            tick();
        end
`ifdef PIPE_STAGE_REG_STALL_CNT_EN
        check("s3 stall_cnt", {16'd0, sc[1]}, 32'd5);
`endif
        ordy[1] = 1'b1;
        #1;
        check("s3 shift in_ready", {31'd0, ir[1]}, 32'd1);
        tick();
        iv[1] = 1'b0;
        check("s3 shift occupancy", dut_occ(1), 32'd3);
        check("s3 shift out_data", dut_od(1), 32'h11);
        repeat (4) tick();

        // Two stages full, flush while offering input.
        ordy[2] = 1'b0;
        for (int t = 0; t < 2; t++) begin
            iv[2]   = 1'b1;
            idat[2] = 8'h30 + 8'(t);
            tick();
        end
        check("s2 full occupancy", dut_occ(2), 32'd2);
        fl[2]   = 1'b1;
        idat[2] = 8'h32;
        #1;
        check("s2 flush in_ready", {31'd0, ir[2]}, 32'd0);
        check("s2 flush out_valid held", {31'd0, ov[2]}, 32'd1);
        tick();
        fl[2] = 1'b0;
        iv[2] = 1'b0;
        check("s2 post-flush occupancy", dut_occ(2), 32'd0);
        check("s2 post-flush out_valid", {31'd0, ov[2]}, 32'd0);
        tick();
        check("s2 flush no capture", {31'd0, ov[2]}, 32'd0);

        // Asynchronous reset between edges with two stages full.
        for (int t = 0; t < 2; t++) begin
            iv[2]   = 1'b1;
            idat[2] = 8'h38 + 8'(t);
            tick();
        end
        iv[2] = 1'b0;
        check("s2 pre-reset occupancy", dut_occ(2), 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        check("s2 async reset out_valid", {31'd0, ov[2]}, 32'd0);
        check("s2 async reset occupancy", dut_occ(2), 32'd0);
        check("s2 async reset in_ready", {31'd0, ir[2]}, 32'd1);
        tick();
        tick();
        rst_n   = 1'b1;
        ordy[2] = 1'b1;
        iv[2]   = 1'b1;
        idat[2] = 8'h40;
        tick();
        iv[2] = 1'b0;
        check("s2 first accept occupancy", dut_occ(2), 32'd1);
        tick();
        check("s2 first accept out_data", dut_od(2), 32'h40);

        // Mixed traffic with irregular valid/ready and one flush, model-checked.
        iv_pat = 24'hB5E3A7;
        rd_pat = 24'h6DB3CF;
        for (int t = 0; t < 24; t++) begin
            for (int k = 1; k < 3; k++) begin
                iv[k]   = iv_pat[t];
                ordy[k] = rd_pat[t];
                fl[k]   = (t == 17);
                idat[k] = 8'h50 + 8'(t);
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            iv[k]   = 1'b0;
            ordy[k] = 1'b1;
            fl[k]   = 1'b0;
        end
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 3, payload bit width per stage (1..64).
REQ-002 Parameter STAGES, default 1, number of register stages in series (1..4).
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  upstream offers in_data this cycle.
REQ-006 Port in_ready  output  1  stage 0 can capture in_data this cycle.
REQ-007 Port in_data  input  WIDTH  payload from upstream.
REQ-008 Port out_valid  output  1  last stage holds a valid payload.
REQ-009 Port out_ready  input  1  downstream consumes out_data this cycle.
REQ-010 Port out_data  output  WIDTH  payload of the last stage.
REQ-011 Port flush  input  1  synchronous squash of all held payloads.
REQ-012 Port occupancy  output  $clog2(STAGES+1)  count of valid stages.
REQ-013 Port stall_cnt  output  16  stall counter; present only under the macro in REQ-032.

Function
REQ-014 Each stage i SHALL hold data_i (WIDTH bits) and valid_i (1 bit); stage 0 is fed by in_data, stage STAGES-1 drives out_data/out_valid directly from flops.
REQ-015 ready_i SHALL be !valid_i || ready_{i+1}, with ready_{STAGES} = out_ready; in_ready = ready_0 && !flush.
REQ-016 A transfer into stage i SHALL occur when the upstream is valid and ready_i is 1; on transfer, data_i and valid_i load from the upstream on the same edge.
REQ-017 When ready_i is 1 and the upstream is not valid, valid_i SHALL clear; data_i is don't-care.
REQ-018 When ready_i is 0, stage i SHALL hold data_i and valid_i unchanged (stall).
REQ-019 Latency SHALL be exactly STAGES cycles from an accepted input to out_valid with no downstream stall.
REQ-020 Throughput SHALL be one payload per cycle while out_ready is held 1; no bubbles are inserted.
REQ-021 Simultaneous pop and push on a full pipeline (all valid, out_ready=1, in_valid=1) SHALL shift all stages and accept the input in the same cycle.
REQ-022 Payload order SHALL be preserved; no payload is duplicated or dropped except by flush.
REQ-023 flush=1 SHALL clear every valid_i on the next edge, overriding any load; in_ready is 0 during flush and the offered input is not captured.
REQ-024 out_valid SHALL remain as registered during the flush cycle; a consumption with out_ready=1 in that cycle is a completed transfer.
REQ-025 occupancy SHALL be a registered count equal to the number of set valid_i after each edge (0..STAGES).
REQ-026 out_data SHALL not change while out_valid=1 and out_ready=0.

Reset
REQ-027 Asserting rst_n=0 SHALL clear all valid_i immediately, independent of clk.
REQ-028 During and after reset: out_valid=0, occupancy=0, stall_cnt=0 (when present), in_ready=1 (given flush=0).
REQ-029 Data registers SHALL reset to 0.
REQ-030 Reset asserted mid-transfer SHALL discard all in-flight payloads; the first edge after rst_n deasserts may accept input.
REQ-031 rst_n is assumed synchronously deasserted by the system; no internal synchroniser.

Configuration
REQ-032 Macro PIPE_STAGE_REG_STALL_CNT_EN defined: stall_cnt exists and increments by 1 on each edge where out_valid=1 and out_ready=0, saturating at 16'hFFFF; cleared only by reset.
REQ-033 Macro undefined: port stall_cnt and its counter are absent; all other behaviour is identical.

Verification
REQ-034 WIDTH=3, STAGES=1: in_data=3'b101 accepted at cycle 0, out_ready=1 -> out_valid=1, out_data=3'b101 at cycle 1, occupancy=1.
REQ-035 STAGES=3, stream 0x1,0x2,0x3,0x4 back-to-back, out_ready=1 -> outputs 0x1..0x4 on cycles 3..6 consecutively, in_ready stays 1.
REQ-036 STAGES=3 full (occupancy=3), out_ready=0 for 5 cycles -> in_ready=0, out_data stable, stall_cnt=5 (macro on); then out_ready=1 with in_valid=1 -> shift and accept in one cycle, occupancy stays 3.
REQ-037 STAGES=2, occupancy=2, flush=1 with in_valid=1 -> in_ready=0, next cycle occupancy=0, out_valid=0, input not captured.
REQ-038 STAGES=2, rst_n pulled low between edges with occupancy=2 -> out_valid=0 and occupancy=0 immediately, before next clk edge.
REQ-039 Macro undefined build: REQ-035 stream produces identical outputs and stall_cnt port absent.
